rx_deframe: RTL and testbench

RX_DEFRAME -- requirements
Module: rx_deframe

---
 rtl/rx_deframe.sv | 277 +++++++++++++++++++++++++++
 tb/tb_rx_deframe.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_deframe.sv
// rx_deframe: checks a received 11-bit UART frame and queues {errors, data} for the host.
// Latency: an entry becomes visible 3 baud_clk edges after the frame event (IDLE -> CHECK -> PUSH).
// Backpressure: none toward the SIPO stage; a frame that cannot be accepted is dropped and flagged in overrun.
//
// Ports:
//   baud_clk, reset_n            - sampling clock, asynchronous active-low reset
//   recieved_flag, data_parll    - frame-complete strobe and frame {start, d0..d7, parity, stop}
//   parity_type                  - 01 odd, 10 even, 00/11 none
//   rd_en                        - pop the head entry (ignored when empty)
//   clr_overrun                  - clear the sticky overrun flag
//   data_out, *_error            - head entry (all zero when empty)
//   data_valid, fifo_full        - buffer status
//   overrun                      - sticky frame-lost flag
//
// Build option: define RX_DEFRAME_FIFO_EN for a 4-entry FIFO; otherwise a single holding register.

module rx_deframe (
  input  logic        baud_clk,
  input  logic        reset_n,
  input  logic        recieved_flag,
  input  logic [10:0] data_parll,
  input  logic [1:0]  parity_type,
  input  logic        rd_en,
  input  logic        clr_overrun,
  output logic [7:0]  data_out,
  output logic        parity_error,
  output logic        start_error,
  output logic        stop_error,
  output logic        data_valid,
  output logic        fifo_full,
  output logic        overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    PUSH  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        flag_q;
  logic        armed;
  logic        frame_evt;

  logic [10:0] frame_reg;
  logic        perr_q;
  logic        serr_q;
  logic        sterr_q;

  logic        latch_frame;
  logic        latch_flags;
  logic        push_req;

  logic [7:0]  frame_byte;
  logic        par_x;
  logic        perr_calc;

  logic [10:0] wr_entry;
  logic [10:0] head;
  logic        empty;
  logic        full;
  logic        pop;
  logic        wr_en;
  logic        push_drop;
  logic        ovr_set;

  // ---------------------------------------------------------------------------
  // Frame event detection. The registered copy is cleared by reset, so a flag
  // held high through reset would look like a rising edge on release; 'armed'
  // only goes high once the flag has been seen low, so the first event after
  // reset is always a genuine new edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      flag_q <= 1'b0;
      armed  <= 1'b0;
    end else begin
      flag_q <= recieved_flag;
      if (!recieved_flag) begin
        armed <= 1'b1;
      end
    end
  end

  assign frame_evt = recieved_flag & ~flag_q & armed;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    latch_frame = 1'b0;
    latch_flags = 1'b0;
    push_req    = 1'b0;
    case (state)
      IDLE: begin
        if (frame_evt) begin
          latch_frame = 1'b1;
          state_nxt   = CHECK;
        end
      end
      CHECK: begin
        latch_flags = 1'b1;
        state_nxt   = PUSH;
      end
      PUSH: begin
        push_req  = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame checking
  // ---------------------------------------------------------------------------
  // d0 sits at frame bit 9 (first bit on the wire), so the byte is bit-reversed.
  always_comb begin
    frame_byte = '0;
    for (int i = 0; i < 8; i++) begin
      frame_byte[i] = frame_reg[9-i];
    end
  end

  // XOR across data plus parity bit: 1 means an odd count of ones.
  assign par_x = ^frame_reg[9:1];

  always_comb begin
    perr_calc = 1'b0;
    case (parity_type)
      2'b01:   perr_calc = ~par_x;
      2'b10:   perr_calc = par_x;
      default: perr_calc = 1'b0;
    endcase
  end

  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_reg <= '0;
      perr_q    <= 1'b0;
      serr_q    <= 1'b0;
      sterr_q   <= 1'b0;
    end else begin
      if (latch_frame) begin
        frame_reg <= data_parll;
      end
      if (latch_flags) begin
        perr_q  <= perr_calc;
        serr_q  <= frame_reg[10];
        sterr_q <= ~frame_reg[0];
      end
    end
  end

  assign wr_entry = {perr_q, serr_q, sterr_q, frame_byte};

  // ---------------------------------------------------------------------------
  // Buffer control. A push into a full buffer still succeeds when a pop frees
  // the head slot on the same edge.
  // ---------------------------------------------------------------------------
  assign pop       = rd_en & ~empty;
  assign wr_en     = push_req & (~full | pop);
  assign push_drop = push_req & full & ~pop;

`ifdef RX_DEFRAME_FIFO_EN
  localparam int            DEPTH     = 4;
  localparam int            PW        = 2;
  localparam logic [PW:0]   CNT_FULL  = 3'd4;
  localparam logic [PW:0]   CNT_ONE   = 3'd1;
  localparam logic [PW-1:0] PTR_ONE   = 2'd1;

  logic [10:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  // Storage needs no reset: nothing is visible until count says so.
  always_ff @(posedge baud_clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Pointers are exactly log2(DEPTH) bits, so increment wraps modulo DEPTH.
  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);
  assign head  = mem[rd_ptr];
`else
  logic [10:0] hold_q;
  logic        hold_vld;

  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q   <= '0;
      hold_vld <= 1'b0;
    end else begin
      if (wr_en) begin
        hold_q   <= wr_entry;
        hold_vld <= 1'b1;
      end else if (pop) begin
        hold_vld <= 1'b0;
      end
    end
  end

  assign empty = ~hold_vld;
  assign full  = hold_vld;
  assign head  = hold_q;
`endif

  // ---------------------------------------------------------------------------
  // Overrun: sticky; a coinciding set beats the clear.
  // ---------------------------------------------------------------------------
  assign ovr_set = (frame_evt & (state != IDLE)) | push_drop;

  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if (ovr_set) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: head entry shown combinationally, forced to zero when empty.
  // ---------------------------------------------------------------------------
  assign data_valid = ~empty;
  assign fifo_full  = full;

  always_comb begin
    data_out     = 8'h00;
    parity_error = 1'b0;
    start_error  = 1'b0;
    stop_error   = 1'b0;
    if (!empty) begin
      data_out     = head[7:0];
      parity_error = head[10];
      start_error  = head[9];
      stop_error   = head[8];
    end
  end

endmodule

// File: tb/tb_rx_deframe.sv
// tb_rx_deframe: self-checking bench for rx_deframe.
// Table of frame vectors with hand-derived expectations, plus sequences for
// buffer fill/overflow, push-with-pop, ignored events and reset abort.

module tb_rx_deframe;

`ifdef RX_DEFRAME_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic        baud_clk;
  logic        reset_n;
  logic        recieved_flag;
  logic [10:0] data_parll;
  logic [1:0]  parity_type;
  logic        rd_en;
  logic        clr_overrun;
  logic [7:0]  data_out;
  logic        parity_error;
  logic        start_error;
  logic        stop_error;
  logic        data_valid;
  logic        fifo_full;
  logic        overrun;

  rx_deframe dut (
    .baud_clk      (baud_clk),
    .reset_n       (reset_n),
    .recieved_flag (recieved_flag),
    .data_parll    (data_parll),
    .parity_type   (parity_type),
    .rd_en         (rd_en),
    .clr_overrun   (clr_overrun),
    .data_out      (data_out),
    .parity_error  (parity_error),
    .start_error   (start_error),
    .stop_error    (stop_error),
    .data_valid    (data_valid),
    .fifo_full     (fifo_full),
    .overrun       (overrun)
  );

  initial baud_clk = 1'b0;
  always #5 baud_clk = ~baud_clk;

  typedef struct {
    logic [10:0] frame;
    logic [1:0]  pt;
    logic [7:0]  data;
    logic        pe;
    logic        se;
    logic        st;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [10:0] sb[$];   // expected {parity_err, start_err, stop_err, data}
  vec_t        vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge baud_clk);
    #1;
  endtask

  // Raises the flag for one edge (the frame event edge).
  task automatic send(input logic [10:0] f);
    data_parll    = f;
    recieved_flag = 1'b1;
    tick();
    recieved_flag = 1'b0;
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  // Compares the DUT head entry with the oldest scoreboard entry.
  task automatic check_head(input string tag);
    logic [10:0] e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_sb: scoreboard empty, nothing expected", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"}, 32'(data_valid), 32'd1);
      chk({tag, "_data"}, 32'(data_out), 32'(e[7:0]));
      chk({tag, "_errs"}, 32'({parity_error, start_error, stop_error}), 32'(e[10:8]));
    end
  endtask

  // Clean frame: start 0, stop 1, parity bit 0, d0 at bit 9.
  function automatic logic [10:0] mkframe(input logic [7:0] d);
    logic [10:0] f;
    f = 11'b000_0000_0001;
    for (int i = 0; i < 8; i++) begin
      f[9-i] = d[i];
    end
    return f;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //            frame    pt     data   pe    se    st
    vecs[0]  = '{11'h295, 2'b10, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{11'h295, 2'b01, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{11'h295, 2'b00, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{11'h295, 2'b11, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{11'h294, 2'b00, 8'hA5, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{11'h695, 2'b00, 8'hA5, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{11'h003, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{11'h003, 2'b10, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{11'h7FE, 2'b10, 8'hFF, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{11'h201, 2'b01, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{11'h005, 2'b10, 8'h80, 1'b1, 1'b0, 1'b0};

    reset_n       = 1'b0;
    recieved_flag = 1'b0;
    data_parll    = '0;
    parity_type   = 2'b00;
    rd_en         = 1'b0;
    clr_overrun   = 1'b0;

    // Reset state
    #12;
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_errs", 32'({parity_error, start_error, stop_error}), 32'd0);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    @(negedge baud_clk);
    reset_n = 1'b1;
    tick();
    tick();

    // Table: one frame at a time, checked at the 3rd edge and popped.
    for (int i = 0; i < 11; i++) begin
      parity_type = vecs[i].pt;
      sb.push_back({vecs[i].pe, vecs[i].se, vecs[i].st, vecs[i].data});
      send(vecs[i].frame);
      tick();
      chk($sformatf("v%0d_early", i), 32'(data_valid), 32'd0);
      tick();
      check_head($sformatf("v%0d", i));
      chk($sformatf("v%0d_full", i), 32'(fifo_full), 32'(DEPTH == 1));
      pop_one();
      chk($sformatf("v%0d_popped", i), 32'(data_valid), 32'd0);
      chk($sformatf("v%0d_zero", i), 32'({parity_error, start_error, stop_error, data_out}), 32'd0);
    end

    // Fill past capacity with no reads: last frame dropped, overrun set.
    parity_type = 2'b00;
    for (int k = 1; k <= DEPTH + 1; k++) begin
      if (k <= DEPTH) sb.push_back({3'b000, 8'(k)});
      send(mkframe(8'(k)));
      tick();
      tick();
    end
    chk("fill_full", 32'(fifo_full), 32'd1);
    chk("fill_ovr", 32'(overrun), 32'd1);
    for (int k = 1; k <= DEPTH; k++) begin
      check_head($sformatf("fill%0d", k));
      pop_one();
    end
    chk("fill_empty", 32'(data_valid), 32'd0);
    chk("fill_notfull", 32'(fifo_full), 32'd0);
    chk("fill_ovr_sticky", 32'(overrun), 32'd1);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    chk("fill_ovr_clr", 32'(overrun), 32'd0);

    // Reading while empty must be ignored.
    rd_en = 1'b1;
    tick();
    tick();
    rd_en = 1'b0;
    chk("empty_rd_valid", 32'(data_valid), 32'd0);

    // Fill to capacity, then push with a simultaneous pop.
    sb.push_back({3'b000, 8'h3C});
    send(mkframe(8'h3C));
    tick();
    tick();
    for (int k = 1; k < DEPTH; k++) begin
      sb.push_back({3'b000, 8'(8'h40 + k)});
      send(mkframe(8'(8'h40 + k)));
      tick();
      tick();
    end
    chk("pp_full_before", 32'(fifo_full), 32'd1);
    sb.push_back({3'b000, 8'h77});
    send(mkframe(8'h77));
    tick();
    check_head("pp_head");
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("pp_full_after", 32'(fifo_full), 32'd1);
    chk("pp_ovr", 32'(overrun), 32'd0);
    for (int k = 0; k < DEPTH; k++) begin
      check_head($sformatf("pp_drain%0d", k));
      pop_one();
    end
    chk("pp_empty", 32'(data_valid), 32'd0);

    // Event while busy is ignored and sets overrun; set beats a coinciding clear.
    sb.push_back({3'b000, 8'h5A});
    send(mkframe(8'h5A));
    tick();
    recieved_flag = 1'b1;
    clr_overrun   = 1'b1;
    data_parll    = mkframe(8'hEE);
    tick();
    recieved_flag = 1'b0;
    clr_overrun   = 1'b0;
    chk("busy_ovr", 32'(overrun), 32'd1);
    tick();
    tick();
    tick();
    check_head("busy_head");
    pop_one();
    chk("busy_no_extra", 32'(data_valid), 32'd0);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    chk("busy_ovr_clr", 32'(overrun), 32'd0);

    // Reset while in CHECK with an entry already buffered.
    send(mkframe(8'h11));
    tick();
    tick();
    send(mkframe(8'h22));
    #2;
    reset_n = 1'b0;
    #1;
    chk("ra_valid", 32'(data_valid), 32'd0);
    chk("ra_outs", 32'({parity_error, start_error, stop_error, data_out}), 32'd0);
    chk("ra_full", 32'(fifo_full), 32'd0);
    #2;
    reset_n = 1'b1;
    sb.delete();
    tick();
    tick();
    tick();
    tick();
    chk("ra_no_late", 32'(data_valid), 32'd0);
    sb.push_back({3'b000, 8'h99});
    send(mkframe(8'h99));
    tick();
    tick();
    check_head("ra_next");
    pop_one();
    chk("ra_end_empty", 32'(data_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
